// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between the instruction cache
// (line reads) and the data cache (line reads and write-backs). One full-line
// transaction is in flight at a time; the winner's command is latched onto the
// mem_* side and the memory response is routed back to the granted cache only.
module pmem_arbiter #(
   parameter int LINE_WIDTH  = 256,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [31:0]           i_pmem_address,
   input  logic                  i_pmem_read,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,

   input  logic [31:0]           d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,

   output logic [31:0]           mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
   typedef enum logic       {ICACHE, DCACHE} grant_t;

   state_t state;
   grant_t last_grant;
   grant_t next_grant;
   logic   dreq;
   logic   ireq;

   // Arbitration: pick the winner among current requesters.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      next_grant = DCACHE;
      dreq       = d_pmem_read | d_pmem_write;
      ireq       = i_pmem_read;
      if (dreq && ireq) begin
         // On a tie, round-robin gives it to whoever did not win last time.
         if (ROUND_ROBIN && (last_grant == DCACHE))
            next_grant = ICACHE;
         else
            next_grant = DCACHE;
      end else if (ireq) begin
         next_grant = ICACHE;
      end
   end

   // Transaction FSM with registered memory-side command.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst) begin
         state       <= IDLE;
         last_grant  <= ICACHE;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dreq || ireq) begin
                  last_grant <= next_grant;
                  if (next_grant == DCACHE) begin
                     mem_address <= d_pmem_address;
                     mem_wdata   <= d_pmem_wdata;
                     // Read and write together is treated as a write.
                     mem_read    <= d_pmem_read & ~d_pmem_write;
                     mem_write   <= d_pmem_write;
                     state       <= SERVE_D;
                  end else begin
                     mem_address <= i_pmem_address;
                     mem_read    <= 1'b1;
                     mem_write   <= 1'b0;
                     state       <= SERVE_I;
                  end
               end
            end
            SERVE_I, SERVE_D: begin
               if (mem_resp) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= DONE;
               end
            end
            // One dead cycle so a cache dropping its request after resp is not re-granted.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Response routing: completion reaches only the granted cache, in the same cycle.
   always_comb begin
      i_pmem_resp  = (state == SERVE_I) && mem_resp;
      d_pmem_resp  = (state == SERVE_D) && mem_resp;
      i_pmem_rdata = mem_rdata;
      d_pmem_rdata = mem_rdata;
   end

   // Simultaneous read and write from the dcache is a protocol error upstream.
   rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
      (state == IDLE) |-> !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter: one round-robin and one fixed-priority
// instance share all stimulus, so their transaction timing stays identical
// while their tie-break decisions can be compared side by side.
module tb_pmem_arbiter;

   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   i_pmem_address;
   logic          i_pmem_read;
   logic [31:0]   d_pmem_address;
   logic [LW-1:0] d_pmem_wdata;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;

   // Round-robin instance outputs
   logic [LW-1:0] r1_i_rdata, r1_d_rdata, r1_mem_wdata;
   logic          r1_i_resp, r1_d_resp, r1_mem_read, r1_mem_write;
   logic [31:0]   r1_mem_address;
   // Fixed-priority instance outputs
   logic [LW-1:0] r0_i_rdata, r0_d_rdata, r0_mem_wdata;
   logic          r0_i_resp, r0_d_resp, r0_mem_read, r0_mem_write;
   logic [31:0]   r0_mem_address;

   int n_cmp = 0;
   int n_err = 0;

   logic [LW-1:0] line_a5;
   logic [LW-1:0] line_12;

   always #5 clk = ~clk;

   pmem_arbiter #(.LINE_WIDTH(LW), .ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
      .i_pmem_rdata(r1_i_rdata), .i_pmem_resp(r1_i_resp),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_rdata(r1_d_rdata), .d_pmem_resp(r1_d_resp),
      .mem_address(r1_mem_address), .mem_wdata(r1_mem_wdata),
      .mem_read(r1_mem_read), .mem_write(r1_mem_write),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   pmem_arbiter #(.LINE_WIDTH(LW), .ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
      .i_pmem_rdata(r0_i_rdata), .i_pmem_resp(r0_i_resp),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_rdata(r0_d_rdata), .d_pmem_resp(r0_d_resp),
      .mem_address(r0_mem_address), .mem_wdata(r0_mem_wdata),
      .mem_read(r0_mem_read), .mem_write(r0_mem_write),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      line_a5 = {32{8'hA5}};
      line_12 = {8{32'h1234_5678}};

      rst = 1'b0;
      i_pmem_address = '0; i_pmem_read = 1'b0;
      d_pmem_address = '0; d_pmem_wdata = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      mem_rdata = '0; mem_resp = 1'b0;

      // ---- Reset state ----
      #3;
      check("rst mem_read",    LW'(r1_mem_read), LW'(0));
      check("rst mem_write",   LW'(r1_mem_write), LW'(0));
      check("rst mem_address", LW'(r1_mem_address), LW'(0));
      check("rst mem_wdata",   r1_mem_wdata, '0);
      check("rst i_resp",      LW'(r1_i_resp), LW'(0));
      check("rst d_resp",      LW'(r1_d_resp), LW'(0));
      tick();
      rst = 1'b1;
      tick();

      // ---- mem_resp in IDLE is ignored ----
      mem_resp = 1'b1;
      #1;
      check("idle resp i", LW'(r1_i_resp), LW'(0));
      check("idle resp d", LW'(r1_d_resp), LW'(0));
      mem_resp = 1'b0;

      // ---- Icache-only read of 0x40 ----
      i_pmem_address = 32'h0000_0040; i_pmem_read = 1'b1;
      tick();
      check("ird mem_read",    LW'(r1_mem_read), LW'(1));
      check("ird mem_write",   LW'(r1_mem_write), LW'(0));
      check("ird mem_address", LW'(r1_mem_address), LW'(32'h40));
      repeat (4) tick();
      check("ird wait i_resp", LW'(r1_i_resp), LW'(0));
      mem_rdata = line_a5; mem_resp = 1'b1;
      #1;
      check("ird i_resp",  LW'(r1_i_resp), LW'(1));
      check("ird i_rdata", r1_i_rdata, line_a5);
      check("ird d_resp",  LW'(r1_d_resp), LW'(0));
      tick();
      mem_resp = 1'b0; i_pmem_read = 1'b0;
      #1;
      check("ird done mem_read", LW'(r1_mem_read), LW'(0));
      check("ird done i_resp",   LW'(r1_i_resp), LW'(0));
      tick();

      // ---- Dcache write-back of 0x1000 ----
      d_pmem_address = 32'h0000_1000; d_pmem_wdata = line_12; d_pmem_write = 1'b1;
      tick();
      check("dwb mem_write",   LW'(r1_mem_write), LW'(1));
      check("dwb mem_read",    LW'(r1_mem_read), LW'(0));
      check("dwb mem_address", LW'(r1_mem_address), LW'(32'h1000));
      check("dwb mem_wdata",   r1_mem_wdata, line_12);
      tick();
      check("dwb wait d_resp", LW'(r1_d_resp), LW'(0));
      mem_resp = 1'b1;
      #1;
      check("dwb d_resp", LW'(r1_d_resp), LW'(1));
      check("dwb i_resp", LW'(r1_i_resp), LW'(0));
      tick();
      mem_resp = 1'b0; d_pmem_write = 1'b0;
      #1;
      check("dwb done mem_write", LW'(r1_mem_write), LW'(0));
      tick();

      // ---- Ties from reset state: RR gives D,I,D,I; fixed priority always D ----
      rst = 1'b0;
      tick();
      rst = 1'b1;
      i_pmem_address = 32'h0000_0400; i_pmem_read = 1'b1;
      d_pmem_address = 32'h0000_0300; d_pmem_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("tie%0d rr addr", k), LW'(r1_mem_address),
               (k % 2 == 0) ? LW'(32'h300) : LW'(32'h400));
         check($sformatf("tie%0d fp addr", k), LW'(r0_mem_address), LW'(32'h300));
         check($sformatf("tie%0d fp read", k), LW'(r0_mem_read), LW'(1));
         tick();
         mem_resp = 1'b1;
         #1;
         check($sformatf("tie%0d rr d_resp", k), LW'(r1_d_resp), (k % 2 == 0) ? LW'(1) : LW'(0));
         check($sformatf("tie%0d rr i_resp", k), LW'(r1_i_resp), (k % 2 == 0) ? LW'(0) : LW'(1));
         check($sformatf("tie%0d fp d_resp", k), LW'(r0_d_resp), LW'(1));
         check($sformatf("tie%0d fp i_resp", k), LW'(r0_i_resp), LW'(0));
         tick();
         mem_resp = 1'b0;
         tick();
      end
      // With the dcache idle, the fixed-priority arbiter finally serves the icache.
      d_pmem_read = 1'b0;
      tick();
      check("fp icache addr", LW'(r0_mem_address), LW'(32'h400));
      check("rr icache addr", LW'(r1_mem_address), LW'(32'h400));
      tick();
      mem_resp = 1'b1;
      #1;
      check("fp icache resp", LW'(r0_i_resp), LW'(1));
      tick();
      mem_resp = 1'b0; i_pmem_read = 1'b0;
      tick();

      // ---- Address change during SERVE_D is ignored ----
      d_pmem_address = 32'h0000_0100; d_pmem_read = 1'b1;
      tick();
      d_pmem_address = 32'h0000_0200;
      tick();
      check("hold addr a", LW'(r1_mem_address), LW'(32'h100));
      tick();
      check("hold addr b", LW'(r1_mem_address), LW'(32'h100));
      mem_resp = 1'b1;
      #1;
      check("hold d_resp", LW'(r1_d_resp), LW'(1));
      tick();
      mem_resp = 1'b0; d_pmem_read = 1'b0;
      tick();

      // ---- Reset during SERVE_I abandons the transaction ----
      i_pmem_address = 32'h0000_0040; i_pmem_read = 1'b1;
      tick();
      check("mid mem_read before", LW'(r1_mem_read), LW'(1));
      rst = 1'b0;
      #1;
      check("mid mem_read reset", LW'(r1_mem_read), LW'(0));
      mem_resp = 1'b1;
      #1;
      check("mid i_resp", LW'(r1_i_resp), LW'(0));
      check("mid d_resp", LW'(r1_d_resp), LW'(0));
      mem_resp = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("post rst mem_read", LW'(r1_mem_read), LW'(1));
      check("post rst addr",     LW'(r1_mem_address), LW'(32'h40));
      mem_resp = 1'b1;
      #1;
      check("post rst i_resp", LW'(r1_i_resp), LW'(1));
      tick();
      mem_resp = 1'b0; i_pmem_read = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
